lsq_moment_acc: RTL and testbench



---
 rtl/lsq_pkg.sv | 39 +++
 rtl/lsq_pow_pipe.sv | 90 +++++++++
 rtl/lsq_moment_acc.sv | 161 ++++++++++++++++
 tb/tb_lsq_moment_acc.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// rtl/lsq_pkg.sv - shared types, latency and width helpers for the moment accumulator
package lsq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lsq_state_e;

  // Register stages between sample acceptance and the accumulator update.
  localparam int PIPE_LAT = 2;

  // Sample counter width: must hold N_SAMP itself.
  function automatic int lsq_cw(input int n_samp);
    return $clog2(n_samp + 1);
  endfunction

  // Slot width of sum(x^k), sized for the largest power 2*deg.
  function automatic int lsq_sxw(input int n_samp, input int deg, input int xw);
    return 2 * deg * xw + lsq_cw(n_samp);
  endfunction

  // Slot width of sum(x^k * y), sized for the largest power deg.
  function automatic int lsq_syw(input int n_samp, input int deg, input int xw, input int yw);
    return deg * xw + yw + lsq_cw(n_samp);
  endfunction

  // Internal product width wide enough for both x^(2*deg) and x^deg * y.
  function automatic int lsq_mw(input int deg, input int xw, input int yw);
    return (2 * deg * xw > deg * xw + yw) ? 2 * deg * xw : deg * xw + yw;
  endfunction

  // LSB position of moment slot k in a packed moment bus of slot width w.
  function automatic int lsq_slot_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/lsq_pow_pipe.sv
// rtl/lsq_pow_pipe.sv - two-stage exact power/product pipeline with valid and mask chain
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous drop of all in-flight samples
//   in_valid     sample enters stage 1 this cycle
//   in_mask      sample contributes to the moments when high
//   x, y         basis variable and regression target
//   out_valid    stage-2 result valid
//   out_mask     mask travelling with the result
//   pow          x^k for k = 0..2*DEG (k = 0 is the constant 1)
//   pxy          x^k * y for k = 0..DEG
module lsq_pow_pipe
  import lsq_pkg::*;
#(
  parameter int DEG = 2,
  parameter int XW  = 12,
  parameter int YW  = 16,
  localparam int MW = lsq_mw(DEG, XW, YW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic                    in_mask,
  input  logic [XW-1:0]           x,
  input  logic [YW-1:0]           y,
  output logic                    out_valid,
  output logic                    out_mask,
  output logic [2*DEG:0][MW-1:0]  pow,
  output logic [DEG:0][MW-1:0]    pxy
);

  logic [DEG:1][MW-1:0]   pw_c;
  logic [DEG:1][MW-1:0]   s1_pw;
  logic [YW-1:0]          s1_y;
  logic                   s1_valid;
  logic                   s1_mask;
  logic [2*DEG:0][MW-1:0] pow_c;
  logic [DEG:0][MW-1:0]   pxy_c;

  // Stage 1: low powers x^1..x^DEG.
  always_comb begin
    pw_c    = '0;
    pw_c[1] = MW'(x);
    for (int k = 2; k <= DEG; k++) begin
      pw_c[k] = pw_c[k-1] * MW'(x);
    end
  end

  // Stage 2: high powers as x^DEG * x^(k-DEG), so each needs one multiply
  // on registered operands; products with y use the registered low powers.
  always_comb begin
    pow_c    = '0;
    pxy_c    = '0;
    pow_c[0] = MW'(1);
    for (int k = 1; k <= DEG; k++) begin
      pow_c[k] = s1_pw[k];
    end
    for (int k = DEG + 1; k <= 2 * DEG; k++) begin
      pow_c[k] = s1_pw[DEG] * s1_pw[k-DEG];
    end
    pxy_c[0] = MW'(s1_y);
    for (int k = 1; k <= DEG; k++) begin
      pxy_c[k] = s1_pw[k] * MW'(s1_y);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mask   <= 1'b0;
      s1_pw     <= '0;
      s1_y      <= '0;
      out_valid <= 1'b0;
      out_mask  <= 1'b0;
      pow       <= '0;
      pxy       <= '0;
    end else begin
      s1_valid  <= in_valid && !flush;
      s1_mask   <= in_mask;
      s1_pw     <= pw_c;
      s1_y      <= y;
      out_valid <= s1_valid && !flush;
      out_mask  <= s1_mask;
      pow       <= pow_c;
      pxy       <= pxy_c;
    end
  end

endmodule

// File: rtl/lsq_moment_acc.sv
// rtl/lsq_moment_acc.sv - streaming least-squares moment accumulator (sum x^k, sum x^k*y)
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begins a batch when idle
//   clear               synchronous abort, highest priority
//   in_valid/in_ready   sample handshake carrying x_in, y_in
//   in_mask             present only with LSQ_ITM_MASK_EN; 0 = sample counted, not summed
//   busy                high in every state except IDLE
//   out_valid/out_ready result handshake; sxx/sxy held while out_valid
//   sxx                 packed sum x^k, k = 0..2*DEG, k = 0 in LSBs, slot SXW bits
//   sxy                 packed sum x^k*y, k = 0..DEG, k = 0 in LSBs, slot SYW bits
// Slot k of either bus carries k*XF fraction bits.
// Optional feature macro: LSQ_ITM_MASK_EN.
module lsq_moment_acc
  import lsq_pkg::*;
#(
  parameter int N_SAMP = 256,
  parameter int DEG    = 2,
  parameter int XW     = 12,
  parameter int XF     = 4,
  parameter int YW     = 16,
  localparam int CW    = lsq_cw(N_SAMP),
  localparam int SXW   = lsq_sxw(N_SAMP, DEG, XW),
  localparam int SYW   = lsq_syw(N_SAMP, DEG, XW, YW)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XW-1:0]              x_in,
  input  logic [YW-1:0]              y_in,
`ifdef LSQ_ITM_MASK_EN
  input  logic                       in_mask,
`endif
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(2*DEG+1)*SXW-1:0]   sxx,
  output logic [(DEG+1)*SYW-1:0]     sxy
);

  localparam int MW = lsq_mw(DEG, XW, YW);
  localparam int NX = 2 * DEG + 1;
  localparam int NY = DEG + 1;

  if (N_SAMP < 2 || N_SAMP > 4096 || DEG < 1 || DEG > 3 || XF > XW) begin : g_param_check
    $error("lsq_moment_acc: parameter out of range");
  end

  lsq_state_e          state;
  lsq_state_e          state_nxt;
  logic [CW-1:0]       cnt;
  logic [1:0]          drain_cnt;
  logic                accept;
  logic                mask_bit;
  logic                p_valid;
  logic                p_mask;
  logic [NX-1:0][MW-1:0] p_pow;
  logic [NY-1:0][MW-1:0] p_pxy;
  logic [SXW-1:0]      acc_x [NX];
  logic [SYW-1:0]      acc_y [NY];

`ifdef LSQ_ITM_MASK_EN
  assign mask_bit = in_mask;
`else
  assign mask_bit = 1'b1;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_ACC;
      end
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && cnt == CW'(N_SAMP - 1)) state_nxt = ST_DRAIN;
      end
      // The last sample lands in the accumulators PIPE_LAT edges after its
      // accept; DONE follows one edge later so sxx/sxy are final when
      // out_valid rises.
      ST_DRAIN: begin
        if (drain_cnt == 2'(PIPE_LAT)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear) state_nxt = ST_IDLE;
  end

  lsq_pow_pipe #(
    .DEG (DEG),
    .XW  (XW),
    .YW  (YW)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear),
    .in_valid  (accept),
    .in_mask   (mask_bit),
    .x         (x_in),
    .y         (y_in),
    .out_valid (p_valid),
    .out_mask  (p_mask),
    .pow       (p_pow),
    .pxy       (p_pxy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      drain_cnt <= '0;
      for (int k = 0; k < NX; k++) acc_x[k] <= '0;
      for (int k = 0; k < NY; k++) acc_y[k] <= '0;
    end else if (clear) begin
      cnt       <= '0;
      drain_cnt <= '0;
      for (int k = 0; k < NX; k++) acc_x[k] <= '0;
      for (int k = 0; k < NY; k++) acc_y[k] <= '0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (state == ST_IDLE && start) begin
        cnt <= '0;
        for (int k = 0; k < NX; k++) acc_x[k] <= '0;
        for (int k = 0; k < NY; k++) acc_y[k] <= '0;
      end else begin
        if (accept) cnt <= cnt + CW'(1);
        // pow[0] is 1 and pxy[0] is y, so slot 0 counts samples and sums y.
        if (p_valid && p_mask) begin
          for (int k = 0; k < NX; k++) acc_x[k] <= acc_x[k] + SXW'(p_pow[k]);
          for (int k = 0; k < NY; k++) acc_y[k] <= acc_y[k] + SYW'(p_pxy[k]);
        end
      end
    end
  end

  for (genvar gk = 0; gk < NX; gk++) begin : g_sxx
    assign sxx[lsq_slot_lo(gk, SXW) +: SXW] = acc_x[gk];
  end

  for (genvar gk = 0; gk < NY; gk++) begin : g_sxy
    assign sxy[lsq_slot_lo(gk, SYW) +: SYW] = acc_y[gk];
  end

endmodule

// File: tb/tb_lsq_moment_acc.sv
// tb/tb_lsq_moment_acc.sv - self-checking bench for lsq_moment_acc with a sum-of-powers model
module tb_lsq_moment_acc;

  localparam int DEG   = 2;
  localparam int XW    = 12;
  localparam int XF    = 4;
  localparam int YW    = 16;
  localparam int NA    = 4;
  localparam int NB    = 256;
  localparam int NX    = 2 * DEG + 1;
  localparam int NY    = DEG + 1;
  localparam int SXW_A = 2 * DEG * XW + $clog2(NA + 1);
  localparam int SYW_A = DEG * XW + YW + $clog2(NA + 1);
  localparam int SXW_B = 2 * DEG * XW + $clog2(NB + 1);
  localparam int SYW_B = DEG * XW + YW + $clog2(NB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              a_start = 1'b0, a_clear = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0, a_mask = 1'b1;
  logic [XW-1:0]     a_x = '0;
  logic [YW-1:0]     a_y = '0;
  logic              a_in_ready, a_busy, a_out_valid;
  logic [NX*SXW_A-1:0] a_sxx;
  logic [NY*SYW_A-1:0] a_sxy;

  logic              b_start = 1'b0, b_clear = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0, b_mask = 1'b1;
  logic [XW-1:0]     b_x = '0;
  logic [YW-1:0]     b_y = '0;
  logic              b_in_ready, b_busy, b_out_valid;
  logic [NX*SXW_B-1:0] b_sxx;
  logic [NY*SYW_B-1:0] b_sxy;

  lsq_moment_acc #(.N_SAMP(NA), .DEG(DEG), .XW(XW), .XF(XF), .YW(YW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .clear(a_clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .x_in(a_x), .y_in(a_y),
`ifdef LSQ_ITM_MASK_EN
    .in_mask(a_mask),
`endif
    .busy(a_busy), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sxx(a_sxx), .sxy(a_sxy)
  );

  lsq_moment_acc #(.N_SAMP(NB), .DEG(DEG), .XW(XW), .XF(XF), .YW(YW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .clear(b_clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .x_in(b_x), .y_in(b_y),
`ifdef LSQ_ITM_MASK_EN
    .in_mask(b_mask),
`endif
    .busy(b_busy), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sxx(b_sxx), .sxy(b_sxy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model of dut_a: running sums of the accepted samples and the
  // edge at which the result must appear.
  int              edges = 0;
  longint unsigned m_sx [NX];
  longint unsigned m_sy [NY];
  int              m_n = 0;
  bit              m_busy = 1'b0;
  bit              m_known = 1'b1;
  int              m_done_at = -1;

  always @(posedge clk) edges++;

  task automatic m_zero();
    for (int k = 0; k < NX; k++) m_sx[k] = 0;
    for (int k = 0; k < NY; k++) m_sy[k] = 0;
  endtask

  always @(negedge clk) begin
    bit exp_ov, exp_rdy, use_it;
    longint unsigned p;
    if (!rst_n) begin
      m_zero();
      m_n = 0; m_busy = 0; m_known = 1; m_done_at = -1;
      chk("rst_in_ready", a_in_ready, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_sxx_zero", (a_sxx == '0), 1);
      chk("rst_sxy_zero", (a_sxy == '0), 1);
    end else begin
      exp_ov = (m_done_at >= 0) && (edges >= m_done_at);
      if (exp_ov) m_known = 1;
      exp_rdy = m_busy && (m_n < NA);
      chk("busy", a_busy, m_busy);
      chk("in_ready", a_in_ready, exp_rdy);
      chk("out_valid", a_out_valid, exp_ov);
      if (m_known) begin
        for (int k = 0; k < NX; k++) chk($sformatf("sxx[%0d]", k), 64'(a_sxx[k*SXW_A +: SXW_A]), m_sx[k]);
        for (int k = 0; k < NY; k++) chk($sformatf("sxy[%0d]", k), 64'(a_sxy[k*SYW_A +: SYW_A]), m_sy[k]);
      end
      if (a_clear) begin
        m_zero();
        m_n = 0; m_busy = 0; m_known = 1; m_done_at = -1;
      end else begin
        if (!m_busy && a_start) begin
          m_zero();
          m_n = 0; m_busy = 1; m_known = 0;
        end else if (exp_rdy && a_in_valid) begin
          m_n++;
          use_it = 1'b1;
`ifdef LSQ_ITM_MASK_EN
          use_it = a_mask;
`endif
          if (use_it) begin
            p = 1;
            for (int k = 0; k < NX; k++) begin
              m_sx[k] += p;
              if (k < NY) m_sy[k] += p * longint'(a_y);
              p = p * longint'(a_x);
            end
          end
          if (m_n == NA) m_done_at = edges + 4;
        end
        if (exp_ov && a_out_ready) begin
          m_busy = 0;
          m_done_at = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic m, input int gap);
    int t;
    bit acc;
    repeat (gap) tick();
    a_x = x; a_y = y; a_mask = m; a_in_valid = 1'b1;
    t = 0; acc = 1'b0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = a_in_ready;
      tick();
      t++;
    end
    chk("send_accepted", acc, 1);
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait_done();
    int t;
    t = 0;
    while (!a_out_valid && t < 100) begin
      tick();
      t++;
    end
    chk("done_reached", a_out_valid, 1);
  endtask

  task automatic a_ack(input int delay);
    repeat (delay) tick();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic a_pulse_start();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  longint unsigned lit_sx [NX] = '{4, 64, 1024, 16384, 262144};
  longint unsigned lit_sy [NY] = '{40, 640, 10240};

  initial begin
    int t;
    int abort_at;
    longint unsigned p;
    int gaps [4] = '{3, 0, 2, 1};

    rst_n = 1'b0;
    repeat (3) tick();
    chk("b_rst_busy", b_busy, 0);
    chk("b_rst_out_valid", b_out_valid, 0);
    chk("b_rst_sxx_zero", (b_sxx == '0), 1);
    rst_n = 1'b1;
    tick();

    // Basic batch with exact result timing.
    a_pulse_start();
    for (int i = 0; i < NA; i++) a_send(12'd16, 16'd10, 1'b1, 0);
    tick();
    tick();
    chk("basic_ov_before", a_out_valid, 0);
    tick();
    chk("basic_ov_on_time", a_out_valid, 1);
    for (int k = 0; k < NX; k++) chk($sformatf("basic_sxx[%0d]", k), 64'(a_sxx[k*SXW_A +: SXW_A]), lit_sx[k]);
    for (int k = 0; k < NY; k++) chk($sformatf("basic_sxy[%0d]", k), 64'(a_sxy[k*SYW_A +: SYW_A]), lit_sy[k]);

    // Output hold with an ignored start pulse.
    a_pulse_start();
    repeat (9) tick();
    chk("hold_ov", a_out_valid, 1);
    chk("hold_sxx4", 64'(a_sxx[4*SXW_A +: SXW_A]), 262144);
    a_ack(0);
    chk("ack_busy", a_busy, 0);
    chk("ack_ov", a_out_valid, 0);
    chk("retained_sxy2", 64'(a_sxy[2*SYW_A +: SYW_A]), 10240);

    // Back-pressure, then in_valid held through drain.
    a_pulse_start();
    for (int i = 0; i < NA; i++) a_send(12'd16, 16'd10, 1'b1, gaps[i]);
    a_in_valid = 1'b1;
    repeat (2) tick();
    a_in_valid = 1'b0;
    a_wait_done();
    chk("bp_sxx0", 64'(a_sxx[0 +: SXW_A]), 4);
    chk("bp_sxy2", 64'(a_sxy[2*SYW_A +: SYW_A]), 10240);
    a_ack(2);

    // Abort after two samples, then a clean batch.
    a_pulse_start();
    a_send(12'd16, 16'd10, 1'b1, 0);
    a_send(12'd16, 16'd10, 1'b1, 0);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("abort_busy", a_busy, 0);
    chk("abort_ov", a_out_valid, 0);
    chk("abort_sxx_zero", (a_sxx == '0), 1);
    chk("abort_sxy_zero", (a_sxy == '0), 1);
    repeat (3) tick();
    chk("abort_flushed", (a_sxx == '0), 1);
    a_pulse_start();
    for (int i = 0; i < NA; i++) a_send(12'd16, 16'd10, 1'b1, 0);
    a_wait_done();
    chk("rerun_sxx2", 64'(a_sxx[2*SXW_A +: SXW_A]), 1024);
    chk("rerun_sxy1", 64'(a_sxy[1*SYW_A +: SYW_A]), 640);
    a_ack(0);

`ifdef LSQ_ITM_MASK_EN
    a_pulse_start();
    a_send(12'd16, 16'd10, 1'b1, 0);
    a_send(12'd16, 16'd10, 1'b0, 0);
    a_send(12'd16, 16'd10, 1'b1, 0);
    a_send(12'd16, 16'd10, 1'b0, 0);
    a_wait_done();
    chk("mask_sxx0", 64'(a_sxx[0 +: SXW_A]), 2);
    chk("mask_sxx1", 64'(a_sxx[1*SXW_A +: SXW_A]), 32);
    chk("mask_sxy0", 64'(a_sxy[0 +: SYW_A]), 20);
    a_ack(0);
`endif

    // Randomized batches with occasional aborts.
    for (int b = 0; b < 20; b++) begin
      abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NA - 1)) : -1;
      a_pulse_start();
      for (int i = 0; i < NA; i++) begin
        if (i == abort_at) begin
          a_clear = 1'b1;
          tick();
          a_clear = 1'b0;
          break;
        end
        a_send(12'($urandom_range(0, 4095)), 16'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end
      if (abort_at < 0) begin
        a_wait_done();
        a_ack(int'($urandom_range(0, 3)));
      end
      tick();
    end

    // Extreme values on the 256-sample instance.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_x = 12'd4095; b_y = 16'd65535; b_in_valid = 1'b1;
    t = 0;
    while (!b_out_valid && t < 400) begin
      tick();
      t++;
    end
    b_in_valid = 1'b0;
    chk("b_done", b_out_valid, 1);
    p = 1;
    for (int k = 0; k < NX; k++) begin
      chk($sformatf("b_sxx[%0d]", k), 64'(b_sxx[k*SXW_B +: SXW_B]), 256 * p);
      if (k < NY) chk($sformatf("b_sxy[%0d]", k), 64'(b_sxy[k*SYW_B +: SYW_B]), 256 * p * 65535);
      p = p * 4095;
    end
    chk("b_sxx4_literal", 64'(b_sxx[4*SXW_B +: SXW_B]), 64'd71987251059360000);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("b_ack_busy", b_busy, 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
